sdram_arbit: RTL and testbench

Top-level scheduler of the SDRAM controller. It holds the command bus for the init sequencer until initialisation completes. After that it grants the shared bus to one of three requesters: auto-refresh, write burst or read burst. It muxes the granted requester's cmd/addr/bank onto the SDRAM pins. A watchdog aborts any grant that never signals its end.

---
 rtl/sdram_pkg.sv | 12 +
 rtl/sdram_cmd_mux.sv | 34 +++
 rtl/sdram_arbit.sv | 97 +++++++++
 tb/tb_sdram_arbit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, bus widths and arbiter state encoding
package sdram_pkg;
   localparam int ADDR_W = 13;
   localparam int BANK_W = 2;
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;
endpackage

// File: rtl/sdram_cmd_mux.sv
// sdram_cmd_mux: selects the current bus owner's cmd/addr/bank from the arbiter state
// Ports: state in; init/aref/wr/rd cmd, addr (and wr/rd bank) in; cmd/addr/bank out.
// IDLE hands the pins to the init sequencer; ARBIT drives NOP with zero addr/bank.
module sdram_cmd_mux
   import sdram_pkg::*;
#(
   parameter logic [3:0] NOP = 4'b0111
) (
   input  state_t              state,
   input  logic [3:0]          init_cmd,
   input  logic [ADDR_W-1:0]   init_addr,
   input  logic [3:0]          aref_cmd,
   input  logic [ADDR_W-1:0]   aref_addr,
   input  logic [3:0]          wr_cmd,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [BANK_W-1:0]   wr_bank,
   input  logic [3:0]          rd_cmd,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [BANK_W-1:0]   rd_bank,
   output logic [3:0]          cmd,
   output logic [ADDR_W-1:0]   addr,
   output logic [BANK_W-1:0]   bank
);
   assign cmd  = (state == IDLE)  ? init_cmd  :
                 (state == AREF)  ? aref_cmd  :
                 (state == WRITE) ? wr_cmd    :
                 (state == READ)  ? rd_cmd    : NOP;
   assign addr = (state == IDLE)  ? init_addr :
                 (state == AREF)  ? aref_addr :
                 (state == WRITE) ? wr_addr   :
                 (state == READ)  ? rd_addr   : '0;
   assign bank = (state == WRITE) ? wr_bank   :
                 (state == READ)  ? rd_bank   : '0;
endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus scheduler (init hold, refresh/write/read arbitration, watchdog)
// Ports: sclk/s_rst; flag_init_end + init cmd/addr; ref/wr/rd request, end flag, cmd/addr(/bank)
// and grant pulse per requester; sdram_cke/cmd/addr/bank pins; err_timeout abort pulse.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int         TIMEOUT_CYC = 64,
   parameter logic [3:0] CMD_NOP     = 4'b0111
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              flag_init_end,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              ref_req,
   input  logic              flag_ref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   output logic              ref_en,
   input  logic              wr_req,
   input  logic              flag_wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BANK_W-1:0] wr_bank,
   output logic              wr_en,
   input  logic              rd_req,
   input  logic              flag_rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BANK_W-1:0] rd_bank,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic [3:0]        sdram_cmd,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BANK_W-1:0] sdram_bank,
   output logic              err_timeout
);
   state_t     state, nxt;
   logic [7:0] wdt;
   logic       last_wr, busy, end_f, tmo, pick_wr;

   assign sdram_cke = 1'b1;
   assign busy      = state inside {AREF, WRITE, READ};
   // only the current owner's end flag counts; others are ignored
   assign end_f     = (state == AREF && flag_ref_end) || (state == WRITE && flag_wr_end) ||
                      (state == READ && flag_rd_end);
   assign tmo       = busy && wdt == 8'(TIMEOUT_CYC - 1) && !end_f;
   // with both pending, last_wr=1 hands the bus to the reader
   assign pick_wr   = wr_req && (!rd_req || !last_wr);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = flag_init_end ? ARBIT : IDLE;
         ARBIT:   nxt = ref_req ? AREF : pick_wr ? WRITE : rd_req ? READ : ARBIT;
         default: nxt = (end_f || tmo) ? ARBIT : state;
      endcase
   end

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state       <= IDLE;
         ref_en      <= 1'b0;
         wr_en       <= 1'b0;
         rd_en       <= 1'b0;
         err_timeout <= 1'b0;
         last_wr     <= 1'b0;
         wdt         <= '0;
      end else begin
         state       <= nxt;
         ref_en      <= state == ARBIT && nxt == AREF;
         wr_en       <= state == ARBIT && nxt == WRITE;
         rd_en       <= state == ARBIT && nxt == READ;
         err_timeout <= tmo;
         if (state == ARBIT && (nxt == WRITE || nxt == READ))
            last_wr <= nxt == WRITE;
         wdt         <= (busy && nxt == state) ? wdt + 8'd1 : '0;
      end
   end

   sdram_cmd_mux #(.NOP(CMD_NOP)) u_mux (
      .state     (state),
      .init_cmd  (init_cmd),
      .init_addr (init_addr),
      .aref_cmd  (aref_cmd),
      .aref_addr (aref_addr),
      .wr_cmd    (wr_cmd),
      .wr_addr   (wr_addr),
      .wr_bank   (wr_bank),
      .rd_cmd    (rd_cmd),
      .rd_addr   (rd_addr),
      .rd_bank   (rd_bank),
      .cmd       (sdram_cmd),
      .addr      (sdram_addr),
      .bank      (sdram_bank)
   );
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed self-checking bench for sdram_arbit
module tb_sdram_arbit;
   logic        sclk = 1'b0;
   logic        s_rst, flag_init_end;
   logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
   logic [1:0]  wr_bank, rd_bank;
   logic        ref_req, flag_ref_end, wr_req, flag_wr_end, rd_req, flag_rd_end;
   logic        ref_en, wr_en, rd_en, sdram_cke, err_timeout;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_bank;
   int          checks = 0;
   int          errors = 0;

   localparam logic [3:0] NOP = 4'b0111;

   always #5 sclk = ~sclk;

   sdram_arbit dut (
      .sclk(sclk), .s_rst(s_rst), .flag_init_end(flag_init_end),
      .init_cmd(init_cmd), .init_addr(init_addr),
      .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
      .ref_en(ref_en),
      .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
      .wr_bank(wr_bank), .wr_en(wr_en),
      .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
      .rd_bank(rd_bank), .rd_en(rd_en),
      .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
      .sdram_bank(sdram_bank), .err_timeout(err_timeout)
   );

   task automatic test_reset;
      s_rst = 1'b1; flag_init_end = 1'b0;
      init_cmd = 4'b0010; init_addr = 13'h400;
      aref_cmd = 4'b0001; aref_addr = 13'h111;
      wr_cmd = 4'b0100; wr_addr = 13'h0ab; wr_bank = 2'd1;
      rd_cmd = 4'b0101; rd_addr = 13'h0cd; rd_bank = 2'd2;
      ref_req = 0; flag_ref_end = 0; wr_req = 0; flag_wr_end = 0; rd_req = 0; flag_rd_end = 0;
      repeat (2) @(negedge sclk);
      checks++;
      if ({sdram_cmd, sdram_addr, sdram_bank} !== {4'b0010, 13'h400, 2'd0}) begin
         errors++; $display("FAIL reset_pins got %h/%h/%h want 2/400/0", sdram_cmd, sdram_addr, sdram_bank);
      end
      checks++;
      if ({ref_en, wr_en, rd_en, err_timeout, sdram_cke} !== 5'b00001) begin
         errors++; $display("FAIL reset_flags got %b want 00001", {ref_en, wr_en, rd_en, err_timeout, sdram_cke});
      end
      s_rst = 1'b0;
      repeat (2) @(negedge sclk);
      checks++;
      if (sdram_cmd !== 4'b0010) begin
         errors++; $display("FAIL idle_hold got %b want 0010", sdram_cmd);
      end
      flag_init_end = 1'b1;
      @(negedge sclk);
      checks++;
      if ({sdram_cmd, sdram_addr, sdram_bank} !== {NOP, 13'h0, 2'd0}) begin
         errors++; $display("FAIL init_to_arbit got %h/%h/%h want 7/0/0", sdram_cmd, sdram_addr, sdram_bank);
      end
   endtask

   task automatic test_refresh;
      ref_req = 1'b1;
      @(negedge sclk);
      checks++;
      if ({ref_en, sdram_cmd, sdram_addr} !== {1'b1, 4'b0001, 13'h111}) begin
         errors++; $display("FAIL ref_grant got en=%b %b/%h want en=1 0001/111", ref_en, sdram_cmd, sdram_addr);
      end
      ref_req = 1'b0;
      @(negedge sclk);
      checks++;
      if ({ref_en, sdram_cmd} !== {1'b0, 4'b0001}) begin
         errors++; $display("FAIL ref_pulse got en=%b cmd=%b want en=0 cmd=0001", ref_en, sdram_cmd);
      end
      repeat (6) @(negedge sclk);
      checks++;
      if (sdram_cmd !== 4'b0001) begin
         errors++; $display("FAIL ref_hold got %b want 0001", sdram_cmd);
      end
      flag_ref_end = 1'b1;
      @(negedge sclk);
      flag_ref_end = 1'b0;
      checks++;
      if ({sdram_cmd, sdram_addr} !== {NOP, 13'h0}) begin
         errors++; $display("FAIL ref_end got %b/%h want 0111/0", sdram_cmd, sdram_addr);
      end
      @(negedge sclk);
      checks++;
      if ({sdram_cmd, ref_en} !== {NOP, 1'b0}) begin
         errors++; $display("FAIL arbit_idle got %b en=%b want 0111 en=0", sdram_cmd, ref_en);
      end
   endtask

   task automatic test_priority;
      ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      @(negedge sclk);
      checks++;
      if ({ref_en, wr_en, rd_en} !== 3'b100) begin
         errors++; $display("FAIL prio_ref got %b want 100", {ref_en, wr_en, rd_en});
      end
      ref_req = 1'b0;
      @(negedge sclk);
      flag_ref_end = 1'b1;
      @(negedge sclk);
      flag_ref_end = 1'b0;
      checks++;
      if ({sdram_cmd, wr_en, rd_en} !== {NOP, 2'b00}) begin
         errors++; $display("FAIL prio_gap got %b %b want 0111 00", sdram_cmd, {wr_en, rd_en});
      end
      @(negedge sclk);
      checks++;
      if ({wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank} !== {2'b10, 4'b0100, 13'h0ab, 2'd1}) begin
         errors++; $display("FAIL prio_wr got %b %b/%h/%h want 10 0100/0ab/1", {wr_en, rd_en}, sdram_cmd, sdram_addr, sdram_bank);
      end
      @(negedge sclk);
      flag_wr_end = 1'b1;
      @(negedge sclk);
      flag_wr_end = 1'b0;
      @(negedge sclk);
      checks++;
      if ({wr_en, rd_en, sdram_cmd, sdram_addr, sdram_bank} !== {2'b01, 4'b0101, 13'h0cd, 2'd2}) begin
         errors++; $display("FAIL prio_rd got %b %b/%h/%h want 01 0101/0cd/2", {wr_en, rd_en}, sdram_cmd, sdram_addr, sdram_bank);
      end
      @(negedge sclk);
      flag_rd_end = 1'b1;
      @(negedge sclk);
      flag_rd_end = 1'b0;
   endtask

   task automatic test_fairness;
      logic got_w;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 8 && !(wr_en || rd_en); c++) @(negedge sclk);
         got_w = wr_en;
         checks++;
         if ({wr_en, rd_en} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL fair_%0d got %b want %b", i, {wr_en, rd_en}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (i == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
         @(negedge sclk);
         if (got_w) flag_wr_end = 1'b1; else flag_rd_end = 1'b1;
         @(negedge sclk);
         flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      end
   endtask

   task automatic test_watchdog;
      int bad;
      wr_req = 1'b1;
      for (int c = 0; c < 8 && !wr_en; c++) @(negedge sclk);
      wr_req = 1'b0;
      checks++;
      if (wr_en !== 1'b1) begin
         errors++; $display("FAIL wdt_grant got %b want 1", wr_en);
      end
      bad = 0;
      for (int c = 0; c < 63; c++) begin
         @(negedge sclk);
         if (err_timeout !== 1'b0 || sdram_cmd !== 4'b0100) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL wdt_early got %0d bad cycles want 0", bad);
      end
      @(negedge sclk);
      checks++;
      if ({err_timeout, sdram_cmd} !== {1'b1, NOP}) begin
         errors++; $display("FAIL wdt_abort got err=%b cmd=%b want err=1 cmd=0111", err_timeout, sdram_cmd);
      end
      @(negedge sclk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++; $display("FAIL wdt_pulse got %b want 0", err_timeout);
      end
      wr_req = 1'b1;
      for (int c = 0; c < 8 && !wr_en; c++) @(negedge sclk);
      wr_req = 1'b0;
      repeat (63) @(negedge sclk);
      checks++;
      if (sdram_cmd !== 4'b0100) begin
         errors++; $display("FAIL wdt_c64 got %b want 0100", sdram_cmd);
      end
      flag_wr_end = 1'b1;
      @(negedge sclk);
      flag_wr_end = 1'b0;
      checks++;
      if ({err_timeout, sdram_cmd} !== {1'b0, NOP}) begin
         errors++; $display("FAIL wdt_end_wins got err=%b cmd=%b want err=0 cmd=0111", err_timeout, sdram_cmd);
      end
      @(negedge sclk);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++; $display("FAIL wdt_end_late got %b want 0", err_timeout);
      end
   endtask

   task automatic test_mid_reset;
      rd_req = 1'b1;
      for (int c = 0; c < 8 && !rd_en; c++) @(negedge sclk);
      rd_req = 1'b0;
      checks++;
      if ({rd_en, sdram_cmd} !== {1'b1, 4'b0101}) begin
         errors++; $display("FAIL mid_read got en=%b cmd=%b want en=1 cmd=0101", rd_en, sdram_cmd);
      end
      #2 s_rst = 1'b1; flag_init_end = 1'b0;
      #1;
      checks++;
      if ({ref_en, wr_en, rd_en, err_timeout, sdram_cmd, sdram_addr} !== {4'b0000, 4'b0010, 13'h400}) begin
         errors++; $display("FAIL mid_rst got en=%b cmd=%b addr=%h want 0000 0010 400", {ref_en, wr_en, rd_en, err_timeout}, sdram_cmd, sdram_addr);
      end
      @(negedge sclk);
      s_rst = 1'b0;
      repeat (2) @(negedge sclk);
      checks++;
      if (sdram_cmd !== 4'b0010) begin
         errors++; $display("FAIL mid_idle got %b want 0010", sdram_cmd);
      end
      flag_init_end = 1'b1;
      @(negedge sclk);
      checks++;
      if (sdram_cmd !== NOP) begin
         errors++; $display("FAIL mid_reinit got %b want 0111", sdram_cmd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got hang want finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_refresh;
      test_priority;
      test_fairness;
      test_watchdog;
      test_mid_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
